score_meter: RTL
================

SCORE_METER -- requirements
Module: score_meter

Interface
REQ-001 Parameter DIGITS, default 5: number of BCD digits displayed and counted.
REQ-002 Parameter COEFFICIENT, default 40: speed units per one distance unit.
REQ-003 Parameter SPEED_W, default 5: speed input width; 2**SPEED_W-1 < COEFFICIENT SHALL hold (elaboration assertion).
REQ-004 Parameter ACHIEVE_DIGITS, default 2: achievement fires every 10**ACHIEVE_DIGITS units; 1 <= ACHIEVE_DIGITS < DIGITS.
REQ-005 Parameter FLASH_DURATION, default 15; FLASH_ITERATIONS, default 3: half-period in timer pulses, number of blink periods.
REQ-006 clk  input  1  sole clock, rising edge; rst  input  1  reset, asynchronous, active-high.
REQ-007 timer_pulse  input  1  one-cycle frame tick.
REQ-008 speed  input  SPEED_W  current game speed; 0 means stopped.
REQ-009 clear  input  1  one-cycle pulse, new game: zero distance.
REQ-010 game_over  input  1  one-cycle pulse, commit distance to high score.
REQ-011 digits  output  DIGITS x 4  displayed score BCD, index 0 = most significant.
REQ-012 hi_digits  output  DIGITS x 4  high score BCD, index 0 = most significant.
REQ-013 paint  output  1  score visible; hi_valid  output  1  high score exists; new_record  output  1  last game beat high score.

Function
REQ-014 Distance SHALL be held as DIGITS BCD digits; no binary division anywhere.
REQ-015 On timer_pulse with speed != 0: if acc+speed < COEFFICIENT, acc <= acc+speed; else acc <= acc+speed-COEFFICIENT and distance increments by exactly 1, registered next cycle.
REQ-016 Distance SHALL saturate at all-9s; further increments leave it unchanged and raise no achievement.
REQ-017 FSM states IDLE, RUN, FLASH; IDLE when speed == 0, RUN on first cycle speed != 0.
REQ-018 An increment producing nonzero distance with low ACHIEVE_DIGITS digits all 0 SHALL enter FLASH, snapshot the new distance, zero flash timer and iteration count.
REQ-019 In FLASH digits SHALL show the snapshot while counting continues underneath; outside FLASH digits show live distance.
REQ-020 In FLASH the flash timer increments per timer_pulse; paint = 0 for timer 0..FLASH_DURATION-1, 1 for FLASH_DURATION..2*FLASH_DURATION-1, then timer wraps to 0 and iteration increments.
REQ-021 After FLASH_ITERATIONS completed periods FSM SHALL return to RUN with paint = 1 that cycle.
REQ-022 A new achievement during FLASH SHALL restart FLASH with the new snapshot.
REQ-023 speed == 0 in any state SHALL freeze distance/acc, abort FLASH to IDLE, force paint = 1.
REQ-024 clear SHALL zero distance, acc, flash state and new_record, go IDLE, and take priority over a same-cycle timer_pulse.
REQ-025 game_over SHALL compare pre-clear distance: if greater than high score or hi_valid = 0, high score <= distance, new_record <= 1; hi_valid <= 1 always.
REQ-026 game_over and clear in the same cycle: commit per REQ-025, then clear; new_record SHALL end 1 if the commit set it.
REQ-027 High score SHALL survive clear; only rst zeroes it.

Reset
REQ-028 rst SHALL asynchronously set distance, acc, snapshot, high score to 0, state IDLE, paint = 1, hi_valid = 0, new_record = 0.
REQ-029 rst asserted mid-FLASH SHALL abort immediately with paint = 1 while rst is high.

Structure
REQ-030 Package score_meter_pkg SHALL hold default constants and the FSM state enum; GAME_WIDTH-derived X placement stays in the package.
REQ-031 Sub-module bcd_counter (DIGITS-parameterised, saturating increment, clear, carry-out of digit ACHIEVE_DIGITS-1 as achievement hint) SHALL be instantiated once.

Verification
REQ-032 speed=20, 2 pulses -> distance 1 after 2nd pulse, acc 0; speed=31, 40 pulses -> distance 31.
REQ-033 Preload 99 then increment -> digits 00100, FLASH, paint 0 for 15 pulses, 1 for 15, x3, then RUN paint 1, digits live (>100).
REQ-034 Preload all-9s (99999), 10 increments -> digits stay 99999, no FLASH.
REQ-035 Distance 120, game_over -> hi_digits 00120, new_record 1, hi_valid 1; clear; distance 50, game_over -> hi stays 00120, new_record 0.
REQ-036 Mid-FLASH drop speed to 0 -> IDLE, paint 1 next cycle; clear+game_over same cycle at distance 300 -> hi 00300, digits 00000.
REQ-037 Assert rst asynchronously between clock edges mid-FLASH -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/score_meter_pkg.sv
// Shared constants and FSM state type for the score meter.
// Screen placement of the score fields lives here next to the digit-count defaults.
package score_meter_pkg;

  localparam int DIGITS_DEF           = 5;
  localparam int COEFFICIENT_DEF      = 40;
  localparam int SPEED_W_DEF          = 5;
  localparam int ACHIEVE_DIGITS_DEF   = 2;
  localparam int FLASH_DURATION_DEF   = 15;
  localparam int FLASH_ITERATIONS_DEF = 3;

  localparam int GAME_WIDTH = 640;
  localparam int DIGIT_PX   = 20;
  localparam int SCORE_X    = GAME_WIDTH - DIGITS_DEF * DIGIT_PX - 8;
  localparam int HI_X       = SCORE_X - (DIGITS_DEF + 3) * DIGIT_PX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLASH
  } state_e;

endpackage

// File: rtl/score_meter_if.sv
// Game-side connection of the score meter: frame tick, speed, game events and display outputs.
interface score_meter_if
  import score_meter_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int SPEED_W = SPEED_W_DEF
);
  logic               timer_pulse;
  logic [SPEED_W-1:0] speed;
  logic               clear;
  logic               game_over;
  logic [3:0]         digits    [DIGITS];
  logic [3:0]         hi_digits [DIGITS];
  logic               paint;
  logic               hi_valid;
  logic               new_record;

  modport master (
    output timer_pulse, speed, clear, game_over,
    input  digits, hi_digits, paint, hi_valid, new_record
  );

  modport slave (
    input  timer_pulse, speed, clear, game_over,
    output digits, hi_digits, paint, hi_valid, new_record
  );
endinterface

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD counter, digit 0 least significant.
// achieve_o flags an increment that carries out of the low ACHIEVE_DIGITS digits.
module bcd_counter
  import score_meter_pkg::*;
#(
  parameter int DIGITS         = DIGITS_DEF,
  parameter int ACHIEVE_DIGITS = ACHIEVE_DIGITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   inc_i,
  output logic [DIGITS-1:0][3:0] count_o,
  output logic [DIGITS-1:0][3:0] next_o,
  output logic                   achieve_o
);

  logic [DIGITS-1:0][3:0] count_q, count_d;
  logic                   all9;
  logic                   low_all9;

  always_comb begin
    all9     = 1'b1;
    low_all9 = 1'b0;
    next_o   = count_q;
    // all9 holds "every digit below i is 9", i.e. the carry into digit i
    for (int i = 0; i < DIGITS; i++) begin
      if (all9) next_o[i] = (count_q[i] == 4'd9) ? 4'd0 : count_q[i] + 4'd1;
      all9 = all9 & (count_q[i] == 4'd9);
      if (i == ACHIEVE_DIGITS - 1) low_all9 = all9;
    end
    if (all9) next_o = count_q;
    achieve_o = inc_i && !all9 && low_all9;

    count_d = count_q;
    if (clear_i)    count_d = '0;
    else if (inc_i) count_d = next_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/score_meter.sv
// Runner-game score meter: speed accumulator feeding a BCD distance counter,
// achievement flash FSM, and high-score capture on game over.
module score_meter
  import score_meter_pkg::*;
#(
  parameter int DIGITS           = DIGITS_DEF,
  parameter int COEFFICIENT      = COEFFICIENT_DEF,
  parameter int SPEED_W          = SPEED_W_DEF,
  parameter int ACHIEVE_DIGITS   = ACHIEVE_DIGITS_DEF,
  parameter int FLASH_DURATION   = FLASH_DURATION_DEF,
  parameter int FLASH_ITERATIONS = FLASH_ITERATIONS_DEF
) (
  input logic          clk,
  input logic          rst,
  score_meter_if.slave bus
);

  localparam int ACC_W  = $clog2(2 * COEFFICIENT);
  localparam int TMR_W  = $clog2(2 * FLASH_DURATION);
  localparam int ITER_W = $clog2(FLASH_ITERATIONS + 1);

  if ((2 ** SPEED_W) - 1 >= COEFFICIENT) begin : g_bad_speed_w
    $error("score_meter: max speed must be below COEFFICIENT");
  end
  if (ACHIEVE_DIGITS < 1 || ACHIEVE_DIGITS >= DIGITS) begin : g_bad_achieve
    $error("score_meter: ACHIEVE_DIGITS out of range");
  end

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_sum;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic [DIGITS-1:0][3:0] snap_q, snap_d;
  logic [DIGITS-1:0][3:0] hi_q, hi_d;
  logic                   hi_valid_q, hi_valid_d;
  logic                   new_record_q, new_record_d;

  logic                   tick, wrap, inc, achieve, beats;
  logic [DIGITS-1:0][3:0] count, count_next, shown;

  assign tick    = bus.timer_pulse && (bus.speed != '0) && !bus.clear;
  assign acc_sum = acc_q + ACC_W'(bus.speed);
  assign wrap    = acc_sum >= ACC_W'(COEFFICIENT);
  assign inc     = tick && wrap;

  bcd_counter #(
    .DIGITS        (DIGITS),
    .ACHIEVE_DIGITS(ACHIEVE_DIGITS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (bus.clear),
    .inc_i    (inc),
    .count_o  (count),
    .next_o   (count_next),
    .achieve_o(achieve)
  );

  always_comb begin
    acc_d = acc_q;
    if (bus.clear) acc_d = '0;
    else if (tick) acc_d = wrap ? acc_sum - ACC_W'(COEFFICIENT) : acc_sum;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    iter_d  = iter_q;
    snap_d  = snap_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      iter_d  = '0;
      snap_d  = '0;
    end else if (bus.speed == '0) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      iter_d  = '0;
    end else if (achieve) begin
      state_d = ST_FLASH;
      snap_d  = count_next;
      tmr_d   = '0;
      iter_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLASH: begin
          if (bus.timer_pulse) begin
            if (tmr_q == TMR_W'(2 * FLASH_DURATION - 1)) begin
              tmr_d = '0;
              if (iter_q == ITER_W'(FLASH_ITERATIONS - 1)) begin
                state_d = ST_RUN;
                iter_d  = '0;
              end else begin
                iter_d = iter_q + ITER_W'(1);
              end
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Packed BCD with the most significant digit on top compares like the number itself.
  assign beats = !hi_valid_q || (count > hi_q);

  always_comb begin
    hi_d         = hi_q;
    hi_valid_d   = hi_valid_q;
    new_record_d = new_record_q;
    if (bus.game_over) begin
      if (beats) hi_d = count;
      new_record_d = beats;
      hi_valid_d   = 1'b1;
    end else if (bus.clear) begin
      new_record_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      tmr_q        <= '0;
      iter_q       <= '0;
      snap_q       <= '0;
      hi_q         <= '0;
      hi_valid_q   <= 1'b0;
      new_record_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tmr_q        <= tmr_d;
      iter_q       <= iter_d;
      snap_q       <= snap_d;
      hi_q         <= hi_d;
      hi_valid_q   <= hi_valid_d;
      new_record_q <= new_record_d;
    end
  end

  assign shown = (state_q == ST_FLASH) ? snap_q : count;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      bus.digits[i]    = shown[DIGITS-1-i];
      bus.hi_digits[i] = hi_q[DIGITS-1-i];
    end
  end

  assign bus.paint      = (state_q != ST_FLASH) || (tmr_q >= TMR_W'(FLASH_DURATION));
  assign bus.hi_valid   = hi_valid_q;
  assign bus.new_record = new_record_q;

endmodule
